// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard receiver with glitch filter and timeout, feeding a scan-code decoder
// that turns arrow/WASD make codes into a one-hot heading. A heading never reverses directly.
module ps2_direction_decoder #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 131072
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [3:0] direction,
   output logic [7:0] scan_code,
   output logic       code_valid,
   output logic       frame_err
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
   logic          clk_filt_q, clk_filt_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          fall;

   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_ok_q, par_ok_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [7:0]    scan_q, scan_d;
   logic          cv_q, cv_d;
   logic          fe_q, fe_d;

   logic          ext_q, ext_d, brk_q, brk_d;
   logic [3:0]    dir_q, dir_d;
   logic [3:0]    heading;
   logic [3:0]    opposite;

   // Synchronizers and the filtered clock idle high, so a released reset never looks like an edge.
   // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         data_s1_q  <= 1'b1;
         data_s2_q  <= 1'b1;
         clk_filt_q <= 1'b1;
         filt_cnt_q <= '0;
      end else begin
         clk_s1_q   <= ps2_clk;
         clk_s2_q   <= clk_s1_q;
         data_s1_q  <= ps2_data;
         data_s2_q  <= data_s1_q;
         clk_filt_q <= clk_filt_d;
         filt_cnt_q <= filt_cnt_d;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      clk_filt_d = clk_filt_q;
      filt_cnt_d = '0;
      if (clk_s2_q != clk_filt_q) begin
         if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            clk_filt_d = clk_s2_q;
         end else begin
            filt_cnt_d = filt_cnt_q + FW'(1);
         end
      end
   end

   assign fall = clk_filt_q & ~clk_filt_d;

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_ok_q  <= 1'b0;
         to_cnt_q  <= '0;
         scan_q    <= '0;
         cv_q      <= 1'b0;
         fe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_ok_q  <= par_ok_d;
         to_cnt_q  <= to_cnt_d;
         scan_q    <= scan_d;
         cv_q      <= cv_d;
         fe_q      <= fe_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_ok_d  = par_ok_q;
      to_cnt_d  = '0;
      scan_d    = scan_q;
      cv_d      = 1'b0;
      fe_d      = 1'b0;

      if (state_q != S_IDLE && !fall) begin
         to_cnt_d = to_cnt_q + TW'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (fall) begin
               if (!data_s2_q) begin
                  state_d   = S_DATA;
                  bit_cnt_d = '0;
               end else begin
                  fe_d = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (fall) begin
               shift_d   = {data_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (fall) begin
               par_ok_d = ^{shift_q, data_s2_q};
               state_d  = S_STOP;
            end
         end
         S_STOP: begin
            if (fall) begin
               state_d = S_IDLE;
               if (par_ok_q && data_s2_q) begin
                  scan_d = shift_q;
                  cv_d   = 1'b1;
               end else begin
                  fe_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A stalled partial frame is dropped so the next start bit resynchronises the receiver.
      if (state_q != S_IDLE && !fall && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
         state_d  = S_IDLE;
         fe_d     = 1'b1;
         to_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
         dir_q <= '0;
      end else begin
         ext_q <= ext_d;
         brk_q <= brk_d;
         dir_q <= dir_d;
      end
   end

   assign opposite = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};

   always_comb begin
      ext_d   = ext_q;
      brk_d   = brk_q;
      dir_d   = dir_q;
      heading = '0;
      if (cv_q) begin
         unique case (scan_q)
            8'hE0: ext_d = 1'b1;
            8'hF0: brk_d = 1'b1;
            default: begin
               unique case ({ext_q, scan_q})
                  9'h175, 9'h01D: heading = 4'b0001;
                  9'h172, 9'h01B: heading = 4'b0010;
                  9'h16B, 9'h01C: heading = 4'b0100;
                  9'h174, 9'h023: heading = 4'b1000;
                  default:        heading = 4'b0000;
               endcase
               // Releases are swallowed; a reversal would make the snake run into itself.
               if (!brk_q && heading != 4'b0000 && heading != opposite) begin
                  dir_d = heading;
               end
               ext_d = 1'b0;
               brk_d = 1'b0;
            end
         endcase
      end
   end

   assign direction  = dir_q;
   assign scan_code  = scan_q;
   assign code_valid = cv_q;
   assign frame_err  = fe_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Randomised and directed frames checked against a byte-level model of the keyboard protocol
// and the heading rules.
module tb_ps2_direction_decoder;

   localparam int HALF = 20;
   localparam int TOUT = 1024;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [3:0] direction;
   logic [7:0] scan_code;
   logic       code_valid;
   logic       frame_err;

   ps2_direction_decoder #(
      .FILTER_LEN    (8),
      .TIMEOUT_CYCLES(TOUT)
   ) dut (
      .clk_100MHz(clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .direction (direction),
      .scan_code (scan_code),
      .code_valid(code_valid),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pulse counters and a latency watch: direction may only move the cycle after code_valid.
   int         cv_cnt = 0;
   int         fe_cnt = 0;
   logic       prev_cv = 1'b0;
   logic [3:0] prev_dir = 4'b0000;

   always @(negedge clk) begin
      if (code_valid) cv_cnt++;
      if (frame_err) fe_cnt++;
      if (!reset && direction !== prev_dir) check("dir_latency", prev_cv, 1);
      prev_cv  = code_valid;
      prev_dir = direction;
   end

   // Reference model at the byte level.
   int         exp_cv = 0;
   int         exp_fe = 0;
   logic [7:0] exp_scan = 8'h00;
   int         exp_idx = -1;
   bit         m_ext = 0;
   bit         m_brk = 0;

   function automatic int head_idx(input logic [7:0] b, input bit ext);
      if (ext) begin
         case (b)
            8'h75: return 0;
            8'h72: return 1;
            8'h6B: return 2;
            8'h74: return 3;
            default: return -1;
         endcase
      end
      case (b)
         8'h1D: return 0;
         8'h1B: return 1;
         8'h1C: return 2;
         8'h23: return 3;
         default: return -1;
      endcase
   endfunction

   function automatic logic [3:0] exp_dir();
      return (exp_idx < 0) ? 4'b0000 : 4'(1 << exp_idx);
   endfunction

   task automatic model_byte(input logic [7:0] b, input bit bad);
      int h;
      if (bad) begin
         exp_fe++;
         return;
      end
      exp_cv++;
      exp_scan = b;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         if (!m_brk) begin
            h = head_idx(b, m_ext);
            if (h >= 0 && !(exp_idx >= 0 && (h ^ 1) == exp_idx)) exp_idx = h;
         end
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   task automatic model_reset();
      exp_scan = 8'h00;
      exp_idx  = -1;
      m_ext    = 0;
      m_brk    = 0;
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      ps2_bit(1'b0);
      for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad);
      ps2_bit(1'b1);
      repeat (2 * HALF) @(negedge clk);
      model_byte(b, bad);
   endtask

   task automatic check_state(input string tag);
      check({tag, "_cv"}, cv_cnt, exp_cv);
      check({tag, "_fe"}, fe_cnt, exp_fe);
      check({tag, "_scan"}, scan_code, exp_scan);
      check({tag, "_dir"}, direction, exp_dir());
      check({tag, "_onehot"}, $onehot0(direction), 1);
   endtask

   logic [7:0] pool [11];

   initial begin
      repeat (3) @(negedge clk);
      check("rst_cv", code_valid, 0);
      check("rst_fe", frame_err, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check_state("reset");

      send_frame(8'hE0, 0);
      send_frame(8'h75, 0);
      check_state("ext_up");

      send_frame(8'h1B, 0);
      check_state("reverse");
      send_frame(8'h1C, 0);
      check_state("left");

      send_frame(8'h1D, 1);
      check_state("bad_parity");
      send_frame(8'h1D, 0);
      check_state("up");

      send_frame(8'hE0, 0);
      send_frame(8'hF0, 0);
      send_frame(8'h74, 0);
      check_state("release");
      send_frame(8'h6B, 0);
      check_state("ext_cleared");

      send_partial(8'h23, 3);
      repeat (TOUT + 100) @(negedge clk);
      exp_fe++;
      check_state("timeout");
      send_frame(8'h23, 0);
      check_state("after_timeout");

      ps2_clk = 1'b0;
      repeat (5) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (30) @(negedge clk);
      check_state("glitch");
      send_frame(8'h1B, 0);
      check_state("after_glitch");

      send_partial(8'h55, 3);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (5) @(negedge clk);
      check_state("mid_reset");
      send_frame(8'h72, 0);
      check_state("plain_72");

      pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h00};
      for (int n = 0; n < 40; n++) begin
         logic [7:0] b;
         int k;
         k = $urandom_range(0, 10);
         b = (k == 10) ? 8'($urandom) : pool[k];
         send_frame(b, $urandom_range(0, 7) == 0);
         check_state("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
